// File: rtl/fpu_pkg.sv
// Shared types and constants for the FPU issue controller.
package fpu_pkg;

  typedef enum logic [1:0] {
    OP_ADD  = 2'b00,
    OP_SUB  = 2'b01,
    OP_MUL  = 2'b10,
    OP_RSVD = 2'b11
  } fpu_op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ISSUE = 2'b01,
    WAIT  = 2'b10,
    RESP  = 2'b11
  } state_e;

  // Canonical quiet NaN returned on any error response.
  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  function automatic logic is_rsvd(input logic [1:0] op);
    return op == OP_RSVD;
  endfunction

endpackage

// File: rtl/fpu_timeout_cnt.sv
// Loadable up-counter with clear and enable; flags expiry at TIMEOUT_CYC-1.
module fpu_timeout_cnt
  import fpu_pkg::*;
#(
  parameter int TIMEOUT_CYC = 64,
  parameter int TW          = $clog2(TIMEOUT_CYC + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          load,
  input  logic [TW-1:0] load_val,
  input  logic          en,
  output logic [TW-1:0] count,
  output logic          expired
);

  // Clear has priority over load, load over counting.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       count <= '0;
    else if (clr)  count <= '0;
    else if (load) count <= load_val;
    else if (en)   count <= count + TW'(1);
  end

  // Expiry compare against the last allowed wait cycle.
  always_comb begin
    expired = (count == TW'(TIMEOUT_CYC - 1));
  end

endmodule

// File: rtl/fpu_issue_ctrl.sv
// Issues host FP requests to an FPU datapath and returns the captured result.
//
// state | meaning
// IDLE  | ready for a host request
// ISSUE | one-cycle fpu_valid strobe with latched operands
// WAIT  | waiting for fpu_ready, bounded by the timeout counter
// RESP  | response held on rsp_* until the host accepts it
module fpu_issue_ctrl
  import fpu_pkg::*;
#(
  parameter int nBITS       = 32,
  parameter int TIMEOUT_CYC = 64,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_op,
  input  logic [nBITS-1:0] req_a,
  input  logic [nBITS-1:0] req_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [nBITS-1:0] rsp_data,
  output logic             rsp_err,
  output logic [1:0]       fpu_op,
  output logic [nBITS-1:0] fpu_din1,
  output logic [nBITS-1:0] fpu_din2,
  output logic             fpu_valid,
  input  logic [nBITS-1:0] fpu_result,
  input  logic             fpu_ready,
  output logic             stray_ready,
  output logic [CNT_W-1:0] op_count
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  state_e           state, state_d;
  logic             accept;
  logic             rsp_load;
  logic [nBITS-1:0] rsp_data_d;
  logic             rsp_err_d;
  logic             tmr_clr;
  logic             tmr_en;
  logic             tmr_expired;
  logic [TW-1:0]    tmr_count;
  logic             cnt_inc;
  logic             stray_set;

  fpu_timeout_cnt #(
    .TIMEOUT_CYC (TIMEOUT_CYC),
    .TW          (TW)
  ) u_timeout (
    .clk      (clk),
    .rst      (reset),
    .clr      (tmr_clr),
    .load     (1'b0),
    .load_val ('0),
    .en       (tmr_en),
    .count    (tmr_count),
    .expired  (tmr_expired)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_d;
  end

  // Next-state and datapath-enable decode.
  always_comb begin
    state_d    = state;
    accept     = 1'b0;
    rsp_load   = 1'b0;
    rsp_data_d = fpu_result;
    rsp_err_d  = 1'b0;
    tmr_clr    = 1'b0;
    tmr_en     = 1'b0;
    cnt_inc    = 1'b0;
    stray_set  = 1'b0;
    unique case (state)
      IDLE: begin
        stray_set = fpu_ready;
        if (req_valid) begin
          accept = 1'b1;
          if (is_rsvd(req_op)) begin
            rsp_load   = 1'b1;
            rsp_data_d = QNAN;
            rsp_err_d  = 1'b1;
            state_d    = RESP;
          end else begin
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        tmr_clr = 1'b1;
        if (fpu_ready) begin
          rsp_load = 1'b1;
          state_d  = RESP;
        end else begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        // A ready arriving on the expiry cycle still delivers its result.
        if (fpu_ready) begin
          rsp_load = 1'b1;
          state_d  = RESP;
        end else if (tmr_expired) begin
          rsp_load   = 1'b1;
          rsp_data_d = QNAN;
          rsp_err_d  = 1'b1;
          state_d    = RESP;
        end else begin
          tmr_en = 1'b1;
        end
      end
      RESP: begin
        stray_set = fpu_ready;
        if (rsp_ready) begin
          cnt_inc = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Operand latch; holds until the next accepted request.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fpu_op   <= '0;
      fpu_din1 <= '0;
      fpu_din2 <= '0;
    end else if (accept) begin
      fpu_op   <= req_op;
      fpu_din1 <= req_a;
      fpu_din2 <= req_b;
    end
  end

  // Registered response, frozen once captured.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_data <= '0;
      rsp_err  <= 1'b0;
    end else if (rsp_load) begin
      rsp_data <= rsp_data_d;
      rsp_err  <= rsp_err_d;
    end
  end

  // Completed-response counter and sticky stray-ready flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_count    <= '0;
      stray_ready <= 1'b0;
    end else begin
      if (cnt_inc)   op_count    <= op_count + CNT_W'(1);
      if (stray_set) stray_ready <= 1'b1;
    end
  end

  // Handshake outputs decode from state; reset gates req_ready so it stays low while held.
  always_comb begin
    req_ready = (state == IDLE) && !reset;
    fpu_valid = (state == ISSUE);
    rsp_valid = (state == RESP);
  end

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Directed bench for fpu_issue_ctrl with a response scoreboard.
module tb_fpu_issue_ctrl;
  import fpu_pkg::*;

  localparam int TIMEOUT_CYC = 64;
  localparam int CNT_W       = 16;

  logic             clk = 1'b0;
  logic             reset;
  logic             req_valid;
  logic             req_ready;
  logic [1:0]       req_op;
  logic [31:0]      req_a;
  logic [31:0]      req_b;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [31:0]      rsp_data;
  logic             rsp_err;
  logic [1:0]       fpu_op;
  logic [31:0]      fpu_din1;
  logic [31:0]      fpu_din2;
  logic             fpu_valid;
  logic [31:0]      fpu_result;
  logic             fpu_ready;
  logic             stray_ready;
  logic [CNT_W-1:0] op_count;

  typedef struct packed {
    logic [31:0] data;
    logic        err;
  } rsp_t;

  rsp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   n_issue = 0;

  fpu_issue_ctrl #(
    .nBITS       (32),
    .TIMEOUT_CYC (TIMEOUT_CYC),
    .CNT_W       (CNT_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_op      (req_op),
    .req_a       (req_a),
    .req_b       (req_b),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_data    (rsp_data),
    .rsp_err     (rsp_err),
    .fpu_op      (fpu_op),
    .fpu_din1    (fpu_din1),
    .fpu_din2    (fpu_din2),
    .fpu_valid   (fpu_valid),
    .fpu_result  (fpu_result),
    .fpu_ready   (fpu_ready),
    .stray_ready (stray_ready),
    .op_count    (op_count)
  );

  always #5 clk = ~clk;

  // Count issue strobes seen by the FPU.
  always @(posedge clk) begin
    if (fpu_valid) n_issue++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
      $error("check %s differs", tag);
    end
  endtask

  // Drive one request; returns at the negedge after acceptance.
  task automatic send_req(input string tag, input logic [1:0] op,
                          input logic [31:0] a, input logic [31:0] b);
    int k = 0;
    while (!req_ready && k < 200) begin
      @(negedge clk);
      k++;
    end
    check({tag, "_req_ready"}, {31'b0, req_ready}, 32'd1);
    req_valid = 1'b1;
    req_op    = op;
    req_a     = a;
    req_b     = b;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  // Wait for a response, compare it against the scoreboard head, then accept it.
  task automatic collect_rsp(input string tag);
    int   k = 0;
    rsp_t exp;
    while (!rsp_valid && k < 200) begin
      @(negedge clk);
      k++;
    end
    check({tag, "_rsp_valid"}, {31'b0, rsp_valid}, 32'd1);
    if (rsp_valid && sb.size() > 0) begin
      exp = sb.pop_front();
      check({tag, "_rsp_data"}, rsp_data, exp.data);
      check({tag, "_rsp_err"}, {31'b0, rsp_err}, {31'b0, exp.err});
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
    end
  endtask

  initial begin
    int issue0;
    int cyc;
    reset      = 1'b1;
    req_valid  = 1'b0;
    req_op     = 2'b00;
    req_a      = '0;
    req_b      = '0;
    rsp_ready  = 1'b0;
    fpu_result = '0;
    fpu_ready  = 1'b0;

    // Reset state
    #1;
    check("rst_req_ready", {31'b0, req_ready}, 32'd0);
    check("rst_fpu_valid", {31'b0, fpu_valid}, 32'd0);
    check("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("rst_op_count", {16'b0, op_count}, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    check("idle_req_ready", {31'b0, req_ready}, 32'd1);
    @(negedge clk);

    // 1: ADD, FPU answers four cycles after issue
    issue0 = n_issue;
    sb.push_back('{data: 32'h4040_0000, err: 1'b0});
    send_req("t1", OP_ADD, 32'h3F80_0000, 32'h4000_0000);
    check("t1_fpu_valid", {31'b0, fpu_valid}, 32'd1);
    check("t1_din1", fpu_din1, 32'h3F80_0000);
    check("t1_din2", fpu_din2, 32'h4000_0000);
    check("t1_fpu_op", {30'b0, fpu_op}, {30'b0, OP_ADD});
    check("t1_busy_req_ready", {31'b0, req_ready}, 32'd0);
    @(negedge clk);
    check("t1_valid_drop", {31'b0, fpu_valid}, 32'd0);
    check("t1_din1_hold", fpu_din1, 32'h3F80_0000);
    repeat (2) @(negedge clk);
    fpu_ready  = 1'b1;
    fpu_result = 32'h4040_0000;
    @(negedge clk);
    fpu_ready  = 1'b0;
    fpu_result = 32'hDEAD_BEEF;
    check("t1_rsp_valid_now", {31'b0, rsp_valid}, 32'd1);
    collect_rsp("t1");
    check("t1_op_count", {16'b0, op_count}, 32'd1);
    check("t1_one_strobe", n_issue - issue0, 32'd1);

    // 2: SUB with a zero-latency FPU
    sb.push_back('{data: 32'h4000_0000, err: 1'b0});
    send_req("t2", OP_SUB, 32'h4040_0000, 32'h3F80_0000);
    check("t2_fpu_op", {30'b0, fpu_op}, {30'b0, OP_SUB});
    fpu_ready  = 1'b1;
    fpu_result = 32'h4000_0000;
    @(negedge clk);
    fpu_ready  = 1'b0;
    fpu_result = 32'h0;
    check("t2_rsp_next_cycle", {31'b0, rsp_valid}, 32'd1);
    collect_rsp("t2");
    check("t2_op_count", {16'b0, op_count}, 32'd2);

    // 3: FPU never answers; timeout then late ready
    check("t3_stray_init", {31'b0, stray_ready}, 32'd0);
    sb.push_back('{data: QNAN, err: 1'b1});
    send_req("t3", OP_MUL, 32'h4000_0000, 32'h4000_0000);
    cyc = 0;
    while (!rsp_valid && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    check("t3_timeout_cycles", cyc, TIMEOUT_CYC + 1);
    fpu_ready  = 1'b1;
    fpu_result = 32'h1234_5678;
    @(negedge clk);
    fpu_ready = 1'b0;
    check("t3_stray_set", {31'b0, stray_ready}, 32'd1);
    collect_rsp("t3");
    check("t3_op_count", {16'b0, op_count}, 32'd3);

    // 4: reserved op never reaches the FPU
    issue0 = n_issue;
    sb.push_back('{data: QNAN, err: 1'b1});
    send_req("t4", OP_RSVD, 32'h3F80_0000, 32'h3F80_0000);
    check("t4_rsp_valid", {31'b0, rsp_valid}, 32'd1);
    collect_rsp("t4");
    check("t4_no_strobe", n_issue - issue0, 32'd0);
    check("t4_op_count", {16'b0, op_count}, 32'd4);

    // 5: response backpressure with an ignored request pulse
    sb.push_back('{data: 32'h40C0_0000, err: 1'b0});
    send_req("t5", OP_MUL, 32'h4040_0000, 32'h4000_0000);
    @(negedge clk);
    fpu_ready  = 1'b1;
    fpu_result = 32'h40C0_0000;
    @(negedge clk);
    fpu_ready  = 1'b0;
    fpu_result = 32'hFFFF_FFFF;
    issue0 = n_issue;
    for (int i = 0; i < 10; i++) begin
      check("t5_hold_valid", {31'b0, rsp_valid}, 32'd1);
      check("t5_hold_data", rsp_data, 32'h40C0_0000);
      check("t5_hold_err", {31'b0, rsp_err}, 32'd0);
      check("t5_req_ready", {31'b0, req_ready}, 32'd0);
      req_valid = (i == 3);
      req_op    = OP_ADD;
      req_a     = 32'h1111_1111;
      @(negedge clk);
    end
    req_valid = 1'b0;
    collect_rsp("t5");
    repeat (2) @(negedge clk);
    check("t5_no_accept", n_issue - issue0, 32'd0);
    check("t5_idle", {31'b0, rsp_valid}, 32'd0);
    check("t5_op_count", {16'b0, op_count}, 32'd5);

    // 6: reset during WAIT aborts the request
    send_req("t6a", OP_ADD, 32'h4000_0000, 32'h4000_0000);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("t6_rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("t6_rst_fpu_valid", {31'b0, fpu_valid}, 32'd0);
    check("t6_rst_req_ready", {31'b0, req_ready}, 32'd0);
    check("t6_rst_din1", fpu_din1, 32'h0);
    check("t6_rst_stray", {31'b0, stray_ready}, 32'd0);
    check("t6_rst_op_count", {16'b0, op_count}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    fpu_ready = 1'b1;
    @(negedge clk);
    fpu_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("t6_no_rsp", {31'b0, rsp_valid}, 32'd0);
    sb.push_back('{data: 32'h4080_0000, err: 1'b0});
    send_req("t6b", OP_ADD, 32'h4000_0000, 32'h4000_0000);
    @(negedge clk);
    fpu_ready  = 1'b1;
    fpu_result = 32'h4080_0000;
    @(negedge clk);
    fpu_ready  = 1'b0;
    collect_rsp("t6b");
    check("t6_op_count", {16'b0, op_count}, 32'd1);
    check("t6_sb_empty", sb.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fpu_issue_ctrl.md
Name: fpu_issue_ctrl

Overview:
Initiator side of the FPU operand/valid/ready protocol. It accepts single-precision operation requests from a host through a valid/ready channel and issues each one to an FPU datapath (add/sub/mul) by driving din1/din2/valid. It then waits for the unit's ready pulse, captures the result, and returns it on a response channel. A timeout covers a unit that never answers. The block sits between the command front-end and the FPU arithmetic units.

Parameters:
nBITS, 32, operand/result width; only 32 (IEEE-754 single) supported in this revision
TIMEOUT_CYC, 64, max cycles spent in WAIT before an error response is forced
CNT_W, 16, width of the completed-operation counter

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-high reset
req_valid  input  1  host request valid
req_ready  output  1  block can accept a request
req_op  input  2  operation code (see package)
req_a  input  32  operand A (IEEE-754)
req_b  input  32  operand B (IEEE-754)
rsp_valid  output  1  response valid
rsp_ready  input  1  host accepts response
rsp_data  output  32  result, or canonical qNaN on error
rsp_err  output  1  1 = timeout or reserved op
fpu_op  output  2  operation select to FPU datapath
fpu_din1  output  32  operand 1 to FPU
fpu_din2  output  32  operand 2 to FPU
fpu_valid  output  1  one-cycle issue strobe to FPU
fpu_result  input  32  FPU result
fpu_ready  input  1  FPU result-valid pulse
stray_ready  output  1  sticky: fpu_ready seen while no op outstanding
op_count  output  CNT_W  completed responses (including errors), wraps

Behaviour:
- Reset (asynchronous):
  - State goes to IDLE.
  - All outputs are 0, except req_ready, which is 1 once IDLE is entered after reset deasserts.
  - Latched operands, rsp_data, timer, op_count and stray_ready are cleared.
- IDLE:
  - req_ready=1.
  - On req_valid&&req_ready, latch op/a/b.
  - If op==OP_RSVD, go to RESP with rsp_data=QNAN and rsp_err=1, and never assert fpu_valid. Otherwise go to ISSUE.
- ISSUE (exactly 1 cycle):
  - fpu_valid=1; fpu_op, fpu_din1 and fpu_din2 driven from the latch.
  - Timer cleared.
  - If fpu_ready=1 in this cycle (zero-latency unit), capture fpu_result, set rsp_err=0 and go to RESP. Otherwise go to WAIT.
- WAIT:
  - fpu_valid=0; fpu_op and fpu_din* stay stable (the latch does not change until the next accept).
  - fpu_ready=1: capture fpu_result, set rsp_err=0, go to RESP.
  - Else if timer==TIMEOUT_CYC-1: set rsp_data=QNAN, rsp_err=1, go to RESP.
  - Else the timer increments.
  - If fpu_ready and timeout coincide, fpu_ready wins.
- RESP:
  - rsp_valid=1; rsp_data and rsp_err held stable until rsp_ready.
  - On rsp_valid&&rsp_ready: op_count+=1 (modulo 2^CNT_W), go to IDLE.
  - req_ready=0 in ISSUE, WAIT and RESP. There is no accept in the same cycle as the response handshake.
- Minimum turnaround is 3 cycles for a zero-latency FPU: accept, ISSUE, RESP.
- fpu_ready in IDLE or RESP (including a late ready after a timeout) is ignored for data and sets stray_ready.
  - stray_ready stays set until reset.
- rsp_data is registered and does not follow fpu_result after capture.
- Reset mid-operation aborts immediately:
  - fpu_valid and rsp_valid drop asynchronously.
  - No response is produced for the aborted request.

Decomposition:
- Shared package fpu_pkg holds:
  - op enum: OP_ADD=2'b00, OP_SUB=2'b01, OP_MUL=2'b10, OP_RSVD=2'b11
  - state enum: IDLE, ISSUE, WAIT, RESP
  - constant QNAN=32'h7FC00000
- One natural sub-module, fpu_timeout_cnt: a loadable up-counter with clear, enable and an expiry output at TIMEOUT_CYC-1.
- Everything else lives in a single FSM plus its datapath registers.

Test Plan:
1. ADD, a=32'h3F800000, b=32'h40000000; bench FPU answers with 32'h40400000 after 4 cycles -> fpu_valid high for exactly 1 cycle with matching din1/din2; rsp_data=32'h40400000, rsp_err=0, op_count=1.
2. SUB, a=32'h40400000, b=32'h3F800000, zero-latency FPU (ready in the ISSUE cycle, result 32'h40000000) -> rsp_valid in the next cycle, rsp_data=32'h40000000.
3. FPU never asserts ready -> after TIMEOUT_CYC cycles in WAIT: rsp_data=32'h7FC00000, rsp_err=1. A late fpu_ready then sets stray_ready=1, and rsp_data stays unchanged.
4. req_op=2'b11 -> fpu_valid never asserts; rsp_err=1, rsp_data=QNAN, op_count increments.
5. Response backpressure: rsp_ready held 0 for 10 cycles -> rsp_valid, rsp_data and rsp_err stable; req_ready=0; a req_valid pulse during this window is not accepted.
6. Assert reset during WAIT -> all outputs clear asynchronously. After release, the next request completes normally and op_count=1.
